// File: rtl/card_display_sequencer_if.sv
// Button/number inputs and shared-bus display outputs of the card display sequencer.
interface card_display_sequencer_if #(
    parameter int DIGITS = 6
);
    localparam int PAGES = DIGITS / 3;
    localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic                  botao;
    logic [4*DIGITS-1:0]   numero;
    logic [6:0]            seg;
    logic [2:0]            an;
    logic [PW-1:0]         pagina;

    modport master (
        output botao,
        output numero,
        input  seg,
        input  an,
        input  pagina
    );

    modport slave (
        input  botao,
        input  numero,
        output seg,
        output an,
        output pagina
    );
endinterface

// File: rtl/card_display_sequencer.sv
// Card-number display sequencer: debounced page button, 3-display multiplexed scan, BCD to 7-segment.
// Macro AUTO_SCROLL_EN adds a timed automatic page advance every SCROLL_DIV cycles.
module card_display_sequencer #(
    parameter int DIGITS     = 6,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 16
`ifdef AUTO_SCROLL_EN
    ,
    parameter int SCROLL_DIV = 50_000_000
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    card_display_sequencer_if.slave disp
);
    localparam int PAGES = DIGITS / 3;
    localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int IW    = $clog2(DIGITS) + 1;

    typedef enum logic [1:0] {
        SLOT_0 = 2'd0,
        SLOT_1 = 2'd1,
        SLOT_2 = 2'd2
    } slot_e;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          press;
    logic          page_step;
    logic [PW-1:0] page_q, page_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic          scan_tc;
    slot_e         slot_q, slot_d;
    logic [IW-1:0] digit_idx;
    logic [3:0]    nibble;
    logic [2:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1111110;
            4'd1:    seg_decode = 7'b0110000;
            4'd2:    seg_decode = 7'b1101101;
            4'd3:    seg_decode = 7'b1111001;
            4'd4:    seg_decode = 7'b0110011;
            4'd5:    seg_decode = 7'b1011011;
            4'd6:    seg_decode = 7'b1011111;
            4'd7:    seg_decode = 7'b1110000;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1111011;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // A new level is accepted only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        level_d   = level_q;
        deb_cnt_d = '0;
        press     = 1'b0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                press   = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

`ifdef AUTO_SCROLL_EN
    localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [CW-1:0] scroll_cnt_q, scroll_cnt_d;
    logic          scroll_tc;

    // A press restarts the scroll interval; a coinciding terminal count still steps only once.
    assign scroll_tc = (scroll_cnt_q == CW'(SCROLL_DIV - 1));
    assign page_step = press | scroll_tc;

    always_comb begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
        if (press || scroll_tc) begin
            scroll_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_cnt_q <= '0;
        end else begin
            scroll_cnt_q <= scroll_cnt_d;
        end
    end
`else
    assign page_step = press;
`endif

    always_comb begin
        page_d = page_q;
        if (page_step) begin
            page_d = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;
        end
    end

    assign scan_tc    = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            deb_cnt_q  <= '0;
            page_q     <= '0;
            scan_cnt_q <= '0;
            an_q       <= 3'b000;
            seg_q      <= 7'b0000000;
        end else begin
            // NOTE: state updates are non-blocking so every register samples pre-edge values.
            sync1_q    <= disp.botao;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            deb_cnt_q  <= deb_cnt_d;
            page_q     <= page_d;
            scan_cnt_q <= scan_cnt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    // Scan-slot FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_0;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Scan-slot FSM: next state.
    always_comb begin
        slot_d = slot_q;
        if (scan_tc) begin
            case (slot_q)
                SLOT_0:  slot_d = SLOT_1;
                SLOT_1:  slot_d = SLOT_2;
                default: slot_d = SLOT_0;
            endcase
        end
    end

    // Scan-slot FSM: outputs, registered one cycle later into an_q/seg_q.
    always_comb begin
        case (slot_q)
            SLOT_0:  an_d = 3'b001;
            SLOT_1:  an_d = 3'b010;
            SLOT_2:  an_d = 3'b100;
            default: an_d = 3'b000;
        endcase
        digit_idx = IW'(3) * IW'(page_q) + IW'(slot_q);
        nibble    = disp.numero[{digit_idx, 2'b00} +: 4];
        seg_d     = seg_decode(nibble);
    end

    assign disp.an     = an_q;
    assign disp.seg    = seg_q;
    assign disp.pagina = page_q;
endmodule

// File: tb/tb_card_display_sequencer.sv
// Self-checking bench for card_display_sequencer: decode table, press/bounce/reset sequences, random button stimulus.
module tb_card_display_sequencer;
    localparam int DIGITS     = 6;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 3;
    localparam int PAGES      = DIGITS / 3;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                           S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                           S9 = 7'b1111011, SB = 7'b0000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    card_display_sequencer_if #(.DIGITS(DIGITS)) dif ();

    card_display_sequencer #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (dif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] rom [16];
        rom = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, SB, SB, SB, SB, SB, SB};
        return rom[d];
    endfunction

    // Reference model: slot from the cycle count, debounce as a window of the last DEB_CYCLES samples.
    int         n_edges;
    int         page_m;
    bit         level_m, b1_m, b2_m, all_diff;
    bit         win_q[$];
    int         slot_m, idx_m;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    int         exp_page;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edges = 0; page_m = 0; level_m = 0; b1_m = 0; b2_m = 0;
            win_q.delete();
            exp_an = 3'b000; exp_seg = 7'b0; exp_page = 0;
        end else begin
            slot_m  = (n_edges / SCAN_DIV) % 3;
            idx_m   = 3 * page_m + slot_m;
            exp_an  = 3'(1 << slot_m);
            exp_seg = ref_seg(4'((dif.numero >> (4 * idx_m)) & 24'hF));
            win_q.push_back(b2_m);
            if (win_q.size() > DEB_CYCLES) void'(win_q.pop_front());
            all_diff = (win_q.size() == DEB_CYCLES);
            foreach (win_q[i]) if (win_q[i] == level_m) all_diff = 0;
            if (all_diff) begin
                level_m = ~level_m;
                if (level_m) page_m = (page_m + 1) % PAGES;
            end
            b2_m = b1_m;
            b1_m = dif.botao;
            n_edges++;
            exp_page = page_m;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("model_an", 32'(dif.an), 32'(exp_an));
            check("model_seg", 32'(dif.seg), 32'(exp_seg));
            check("model_pagina", 32'(dif.pagina), 32'(exp_page));
        end
    end

    typedef struct {
        logic [23:0]     numero;
        int              page;
        logic [2:0][6:0] seg;
    } vec_t;

    function automatic vec_t mk(input logic [23:0] num, input int pg,
                                input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        vec_t v;
        v.numero = num;
        v.page   = pg;
        v.seg    = {c, b, a};
        return v;
    endfunction

    task automatic press_release();
        @(negedge clk);
        dif.botao = 1'b1;
        repeat (10) @(negedge clk);
        dif.botao = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic edges_until_page_change(output int k);
        logic [0:0] old;
        old = dif.pagina;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (dif.pagina == old && k < 30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   k;
        int   w;

        vecs[0] = mk(24'h987654, 0, S4, S5, S6);
        vecs[1] = mk(24'hFA0321, 0, S1, S2, S3);
        vecs[2] = mk(24'h000098, 0, S8, S9, S0);
        vecs[3] = mk(24'h00FCBA, 0, SB, SB, SB);
        vecs[4] = mk(24'hFA0321, 1, S0, SB, SB);
        vecs[5] = mk(24'h987654, 1, S7, S8, S9);
        vecs[6] = mk(24'h987654, 0, S4, S5, S6);

        dif.botao  = 1'b0;
        dif.numero = 24'h987654;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_an", 32'(dif.an), 32'h0);
        check("reset_seg", 32'(dif.seg), 32'h0);
        check("reset_pagina", 32'(dif.pagina), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_an", 32'(dif.an), 32'b001);
        check("first_seg", 32'(dif.seg), 32'(S4));

        // Decode table: select the page by pressing, then walk the three scan slots.
        for (int v = 0; v < 7; v++) begin
            for (int t = 0; t < 4 && 32'(dif.pagina) != vecs[v].page; t++) press_release();
            check($sformatf("vec%0d_page", v), 32'(dif.pagina), 32'(vecs[v].page));
            @(negedge clk);
            dif.numero = vecs[v].numero;
            repeat (2) @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                w = 0;
                while (dif.an !== 3'(1 << s) && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check($sformatf("vec%0d_an%0d", v, s), 32'(dif.an), 32'(1 << s));
                check($sformatf("vec%0d_seg%0d", v, s), 32'(dif.seg), 32'(vecs[v].seg[s]));
            end
        end

        // Clean press: accepted on the 5th edge after botao rises, once only while held.
        @(negedge clk);
        dif.botao = 1'b1;
        edges_until_page_change(k);
        check("press_latency", 32'(k), 32'd5);
        check("press_page", 32'(dif.pagina), 32'd1);
        repeat (20) @(negedge clk);
        check("hold_no_repeat", 32'(dif.pagina), 32'd1);
        dif.botao = 1'b0;
        repeat (10) @(negedge clk);
        check("release_no_step", 32'(dif.pagina), 32'd1);

        press_release();
        check("wrap_page", 32'(dif.pagina), 32'd0);

        // Bounce of single-cycle pulses must not be accepted.
        @(negedge clk); dif.botao = 1'b1;
        @(negedge clk); dif.botao = 1'b0;
        @(negedge clk); dif.botao = 1'b1;
        @(negedge clk); dif.botao = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_no_step", 32'(dif.pagina), 32'd0);

        // Reset while the button is held: async clear, then exactly one re-accepted press.
        @(negedge clk);
        dif.botao = 1'b1;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_an", 32'(dif.an), 32'h0);
        check("midreset_seg", 32'(dif.seg), 32'h0);
        check("midreset_pagina", 32'(dif.pagina), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        edges_until_page_change(k);
        check("repress_latency", 32'(k), 32'(2 + DEB_CYCLES));
        repeat (20) @(negedge clk);
        check("repress_once", 32'(dif.pagina), 32'd1);
        dif.botao = 1'b0;
        repeat (10) @(negedge clk);

        // Random button runs and number changes, checked continuously against the model.
        for (int r = 0; r < 200; r++) begin
            @(negedge clk);
            dif.botao = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) dif.numero = 24'($urandom());
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
